ultrasonic_echo_emulator: RTL and testbench

Synthesizable responder for the HC-SR04-style trig/echo protocol that our ultrasonic sensor controller initiates. It accepts a trigger pulse, waits out a fixed burst time, then drives an echo pulse whose width encodes a programmed distance. Out-of-range targets produce the sensor's timeout pulse. It sits on the FPGA in place of the physical sensor for hardware-in-loop testing of the return-and-earn distance path, and runs on the same 50 MHz clock.

---
 rtl/ultrasonic_pkg.sv | 34 +++
 rtl/trig_edge_sync.sv | 32 +++
 rtl/ultrasonic_echo_emulator.sv | 148 ++++++++++++++
 tb/tb_ultrasonic_echo_emulator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared constants, state encoding and count type for the ultrasonic echo emulator
// and the sensor controller it stands in for.
package ultrasonic_pkg;

   localparam int unsigned CLK_HZ          = 50_000_000;
   localparam int unsigned CYCLES_PER_CM   = 2847;
   localparam int unsigned TRIG_MIN_CYCLES = 500;
   localparam int unsigned MAX_CM          = 400;
   localparam int unsigned BURST_CYCLES    = 10_000;
   localparam int unsigned TIMEOUT_CYCLES  = 1_900_000;
   localparam int unsigned HOLDOFF_CYCLES  = 50_000;
   localparam int unsigned DIST_W          = 12;

   typedef logic [23:0]       count_t;
   typedef logic [DIST_W-1:0] dist_t;

   typedef enum logic [2:0] {
      IDLE,
      TRIG_HI,
      BURST,
      ECHO,
      HOLDOFF
   } state_t;

   // Zero or beyond-range targets report the sensor's timeout pulse instead of a width.
   function automatic count_t echoWidth(input dist_t cm, input count_t cyclesPerCm,
                                        input dist_t maxCm, input count_t timeoutCycles);
      count_t w;
      if (cm == '0 || cm > maxCm) w = timeoutCycles;
      else                        w = count_t'(cm) * cyclesPerCm;
      return w;
   endfunction

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchronizer for the incoming trig line followed by registered
// single-cycle rise and fall pulses.
module trig_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic trig_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q, rise_q, fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= trig_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
         fall_q <= ~sync_q & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// Stand-in for an HC-SR04 style sensor: validates trig, waits the burst time, then
// returns an echo pulse whose width encodes the programmed distance.
module ultrasonic_echo_emulator
   import ultrasonic_pkg::*;
#(
   parameter int unsigned TRIG_MIN_CYCLES = ultrasonic_pkg::TRIG_MIN_CYCLES,
   parameter int unsigned BURST_CYCLES    = ultrasonic_pkg::BURST_CYCLES,
   parameter int unsigned CYCLES_PER_CM   = ultrasonic_pkg::CYCLES_PER_CM,
   parameter int unsigned MAX_CM          = ultrasonic_pkg::MAX_CM,
   parameter int unsigned TIMEOUT_CYCLES  = ultrasonic_pkg::TIMEOUT_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES  = ultrasonic_pkg::HOLDOFF_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trig,
   input  logic [11:0] distance_cm,
   output logic        echo,
   output logic        busy,
   output logic        trig_short,
   output logic        out_of_range
);

   localparam count_t ONE          = count_t'(1);
   localparam count_t TRIG_LOAD    = count_t'(TRIG_MIN_CYCLES - 1);
   localparam count_t BURST_LOAD   = count_t'(BURST_CYCLES - 1);
   localparam count_t HOLDOFF_LOAD = count_t'(HOLDOFF_CYCLES - 1);
   localparam count_t CPC          = count_t'(CYCLES_PER_CM);
   localparam count_t TIMEOUT      = count_t'(TIMEOUT_CYCLES);
   localparam dist_t  MAX_D        = dist_t'(MAX_CM);

   logic   trigRise, trigFall;
   state_t state_q, state_d;
   count_t cnt_q, cnt_d;
   count_t width_q;
   dist_t  dist_q;
   logic   calc_q, latch;
   logic   echo_q, echo_d, busy_q, busy_d, trigShort_q, trigShort_d, oor_q;

   trig_edge_sync uSync (
      .clk    (clk),
      .rst    (rst),
      .trig_i (trig),
      .rise_o (trigRise),
      .fall_o (trigFall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // One down-counter serves every timed state; TRIG_HI saturates at zero once the minimum is met.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigRise) begin
               state_d = TRIG_HI;
               cnt_d   = TRIG_LOAD;
            end
         end
         TRIG_HI: begin
            if (trigFall) begin
               if (cnt_q == '0) begin
                  latch   = 1'b1;
                  state_d = BURST;
                  cnt_d   = BURST_LOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end
         end
         BURST: begin
            if (cnt_q == '0) begin
               state_d = ECHO;
               cnt_d   = width_q - ONE;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ECHO: begin
            if (cnt_q == '0) begin
               state_d = HOLDOFF;
               cnt_d   = HOLDOFF_LOAD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         HOLDOFF: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      echo_d      = (state_d == ECHO);
      busy_d      = (state_d != IDLE);
      trigShort_d = (state_q == TRIG_HI) && trigFall && (cnt_q != '0);
   end

   // Width is ready one cycle after the latch, well before BURST ends (BURST_CYCLES >= 2).
   always_ff @(posedge clk) begin
      if (rst) begin
         dist_q      <= '0;
         calc_q      <= 1'b0;
         width_q     <= '0;
         oor_q       <= 1'b0;
         echo_q      <= 1'b0;
         busy_q      <= 1'b0;
         trigShort_q <= 1'b0;
      end else begin
         calc_q      <= latch;
         echo_q      <= echo_d;
         busy_q      <= busy_d;
         trigShort_q <= trigShort_d;
         if (latch) begin
            dist_q <= distance_cm;
            oor_q  <= (distance_cm == '0) || (distance_cm > MAX_D);
         end
         if (calc_q) width_q <= echoWidth(dist_q, CPC, MAX_D, TIMEOUT);
      end
   end

   assign echo         = echo_q;
   assign busy         = busy_q;
   assign trig_short   = trigShort_q;
   assign out_of_range = oor_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed self-checking bench for ultrasonic_echo_emulator using scaled-down timing
// parameters so every scenario fits in a short run.
module tb_ultrasonic_echo_emulator;

   localparam int TRIG_MIN = 5;
   localparam int BURST    = 20;
   localparam int CPC      = 3;
   localparam int MAXCM    = 40;
   localparam int TIMEOUT  = 200;
   localparam int HOLDOFF  = 30;
   // Cycles from trig being driven low to echo first seen high: 2 sync + 1 edge + 1 FSM + BURST.
   localparam int RISE_DELAY = 4 + BURST;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trig = 1'b0;
   logic [11:0] distance_cm = '0;
   logic        echo, busy, trig_short, out_of_range;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int echoRises = 0, echoRiseCyc = 0, echoFallCyc = 0, lastWidth = 0;
   int shorts = 0, shortRiseCyc = 0, shortWidth = 0;
   int fallCyc = 0;
   int riseBase = 0, shortBase = 0;
   logic echoPrev = 1'b0, shortPrev = 1'b0;

   ultrasonic_echo_emulator #(
      .TRIG_MIN_CYCLES (TRIG_MIN),
      .BURST_CYCLES    (BURST),
      .CYCLES_PER_CM   (CPC),
      .MAX_CM          (MAXCM),
      .TIMEOUT_CYCLES  (TIMEOUT),
      .HOLDOFF_CYCLES  (HOLDOFF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .trig         (trig),
      .distance_cm  (distance_cm),
      .echo         (echo),
      .busy         (busy),
      .trig_short   (trig_short),
      .out_of_range (out_of_range)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: records rise cycle and width of echo and trig_short on the falling edge.
   always @(negedge clk) begin
      if (echo && !echoPrev) begin echoRiseCyc = cyc; echoRises++; end
      if (!echo && echoPrev) begin echoFallCyc = cyc; lastWidth = cyc - echoRiseCyc; end
      echoPrev = echo;
      if (trig_short && !shortPrev) begin shortRiseCyc = cyc; shorts++; end
      if (!trig_short && shortPrev) shortWidth = cyc - shortRiseCyc;
      shortPrev = trig_short;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout simulation did not finish in time");
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulseTrig(input int highCycles);
      trig = 1'b1;
      repeat (highCycles) tick();
      trig = 1'b0;
   endtask

   // Program a distance, issue a trig of the given width and scramble the distance afterwards.
   task automatic applyStimulus(input int highCycles, input logic [11:0] cm);
      distance_cm = cm;
      pulseTrig(highCycles);
      fallCyc = cyc;
      repeat (6) tick();
      distance_cm = 12'd999;
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin tick(); n++; end
      checkOutput(tag, int'(busy === 1'b0), 1);
   endtask

   task automatic waitEcho(input string tag, input logic level, input int budget);
      int n = 0;
      while (echo !== level && n < budget) begin tick(); n++; end
      checkOutput(tag, int'(echo === level), 1);
   endtask

   task automatic measure(input string tag, input logic [11:0] cm, input int expWidth, input int expOor);
      riseBase = echoRises;
      applyStimulus(TRIG_MIN, cm);
      waitIdle({tag, "_idle"}, 2000);
      checkOutput({tag, "_rises"}, echoRises - riseBase, 1);
      checkOutput({tag, "_delay"}, echoRiseCyc - fallCyc, RISE_DELAY);
      checkOutput({tag, "_width"}, lastWidth, expWidth);
      checkOutput({tag, "_oor"}, int'(out_of_range), expOor);
   endtask

   initial begin
      repeat (3) tick();
      checkOutput("reset_echo", int'(echo), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_trig_short", int'(trig_short), 0);
      checkOutput("reset_oor", int'(out_of_range), 0);
      rst = 1'b0;
      repeat (3) tick();

      // Nominal measurement at exactly the minimum trig width.
      measure("nominal", 12'd25, 25 * CPC, 0);

      // Trig one cycle too short.
      riseBase  = echoRises;
      shortBase = shorts;
      distance_cm = 12'd10;
      pulseTrig(TRIG_MIN - 1);
      fallCyc = cyc;
      repeat (8) tick();
      checkOutput("short_pulse_count", shorts - shortBase, 1);
      checkOutput("short_pulse_width", shortWidth, 1);
      checkOutput("short_pulse_time", shortRiseCyc - fallCyc, 4);
      checkOutput("short_busy", int'(busy), 0);
      repeat (BURST + 20) tick();
      checkOutput("short_no_echo", echoRises - riseBase, 0);

      // Range boundaries.
      measure("oor_401", 12'd401, TIMEOUT, 1);
      measure("oor_zero", 12'd0, TIMEOUT, 1);
      measure("max_cm", 12'd40, 40 * CPC, 0);
      measure("one_cm", 12'd1, CPC, 0);

      // Trig during ECHO is ignored; trig timed to reach the FSM as HOLDOFF ends is accepted.
      riseBase = echoRises;
      applyStimulus(TRIG_MIN, 12'd20);
      waitEcho("hold_echo_rise", 1'b1, 500);
      pulseTrig(TRIG_MIN);
      waitEcho("hold_echo_fall", 1'b0, 500);
      while (cyc < echoFallCyc + HOLDOFF - 3) tick();
      distance_cm = 12'd15;
      pulseTrig(TRIG_MIN);
      fallCyc = cyc;
      waitIdle("hold_idle", 2000);
      checkOutput("hold_rises", echoRises - riseBase, 2);
      checkOutput("hold_delay", echoRiseCyc - fallCyc, RISE_DELAY);
      checkOutput("hold_width", lastWidth, 15 * CPC);

      // Reset in the middle of an echo, then a clean measurement.
      applyStimulus(TRIG_MIN, 12'd30);
      waitEcho("rst_echo_rise", 1'b1, 500);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      checkOutput("rst_echo", int'(echo), 0);
      checkOutput("rst_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (3) tick();
      measure("post_rst", 12'd12, 12 * CPC, 0);

      // Controller-side view: width divided by cycles-per-cm recovers the distance.
      measure("loopback", 12'd37, 37 * CPC, 0);
      checkOutput("loopback_distance", lastWidth / CPC, 37);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
